// File: rtl/vred_pkg.sv
// vred_pkg: shared op-select encodings, FSM states and op identity for the vector reduction sequencer
package vred_pkg;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCUM, RESP} state_t;

    // Identity bit, replicated to element width by the caller: all-ones for and, zero otherwise
    function automatic logic vred_identity(input logic [1:0] op);
        return op == OP_AND;
    endfunction

endpackage

// File: rtl/vred_lane_tree.sv
// vred_lane_tree: combinational log2(LANES)-level pairwise and/or/xor fold of one beat
module vred_lane_tree
    import vred_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [LANES*DATA_WIDTH-1:0] lanes,
    input  logic [1:0]                  op,
    output logic [DATA_WIDTH-1:0]       folded
);

    localparam int LVLS = $clog2(LANES);

    function automatic logic [DATA_WIDTH-1:0] fold2(input logic [1:0] o, input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        return o == OP_AND ? a & b : o == OP_OR ? a | b : o == OP_XOR ? a ^ b : a;
    endfunction

    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic [(LANES>>l)*DATA_WIDTH-1:0] v;
        if (l == 0) begin : g_in
            assign v = lanes;
        end else begin : g_red
            always_comb begin
                v = '0;
                for (int i = 0; i < (LANES >> l); i++)
                    v[i*DATA_WIDTH +: DATA_WIDTH] = fold2(op, g_lvl[l-1].v[2*i*DATA_WIDTH +: DATA_WIDTH], g_lvl[l-1].v[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    assign folded = g_lvl[LVLS].v;

endmodule

// File: rtl/vred_andorxor_seq.sv
// vred_andorxor_seq: streams operand beats into a seeded and/or/xor scalar accumulator and returns it over valid/ready.
// Define VRED_MASK_EN to add the in_mask port (masked lanes become the op identity).
module vred_andorxor_seq
    import vred_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 4,
    parameter int OPSEL_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_start,
    input  logic [OPSEL_WIDTH-1:0]      in_opSel,
    input  logic [DATA_WIDTH-1:0]       in_seed,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_last,
`ifdef VRED_MASK_EN
    input  logic [LANES-1:0]            in_mask,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_busy
);

    state_t                      state;
    logic [1:0]                  op;
    logic [DATA_WIDTH-1:0]       acc, tree, fold;
    logic [LANES*DATA_WIDTH-1:0] lanes;

`ifdef VRED_MASK_EN
    always_comb begin
        lanes = in_data;
        for (int i = 0; i < LANES; i++)
            lanes[i*DATA_WIDTH +: DATA_WIDTH] = in_mask[i] ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{vred_identity(op)}};
    end
`else
    assign lanes = in_data;
`endif

    vred_lane_tree #(.LANES(LANES), .DATA_WIDTH(DATA_WIDTH)) u_tree (
        .lanes  (lanes),
        .op     (op),
        .folded (tree)
    );

    always_comb fold = op == OP_AND ? acc & tree : op == OP_OR ? acc | tree : op == OP_XOR ? acc ^ tree : acc;

    assign out_data = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            op        <= OP_PASS;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_start) begin
                    acc      <= in_seed;
                    op       <= in_opSel[1:0];
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                    out_busy <= 1'b1;
                end
                ACCUM: if (in_valid) begin
                    acc <= fold;
                    if (in_last) begin
                        state     <= RESP;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                RESP: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vred_andorxor_seq.sv
// tb_vred_andorxor_seq: directed and randomized checks of vred_andorxor_seq against a flat lane-by-lane reference fold.
module tb_vred_andorxor_seq;

    localparam int DW = 32;
    localparam int L  = 4;

    logic            clk = 1'b0, rst = 1'b1;
    logic            in_start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [1:0]      in_opSel = 2'b00;
    logic [DW-1:0]   in_seed = '0;
    logic [L*DW-1:0] in_data = '0;
    logic [L-1:0]    in_mask = '1;
    logic            in_ready, out_valid, out_busy;
    logic [DW-1:0]   out_data;

    int n_cmp = 0, n_bad = 0;
    logic [L*DW-1:0] beat_q[$];
    logic [L-1:0]    mask_q[$];
    int              gap_q[$];
    logic [DW-1:0]   last_res;

    vred_andorxor_seq #(.DATA_WIDTH(DW), .LANES(L), .OPSEL_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .in_opSel  (in_opSel),
        .in_seed   (in_seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef VRED_MASK_EN
        .in_mask   (in_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_busy  (out_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [L-1:0] eff_mask(input logic [L-1:0] m);
`ifdef VRED_MASK_EN
        return m;
`else
        return '1;
`endif
    endfunction

    // Masked lanes simply do not take part in the reduction
    function automatic logic [DW-1:0] ref_fold(input logic [1:0] op, input logic [DW-1:0] acc, input logic [L*DW-1:0] b, input logic [L-1:0] m);
        for (int i = 0; i < L; i++)
            if (m[i])
                case (op)
                    2'b01:   acc = acc & b[i*DW +: DW];
                    2'b10:   acc = acc | b[i*DW +: DW];
                    2'b11:   acc = acc ^ b[i*DW +: DW];
                    default: acc = acc;
                endcase
        return acc;
    endfunction

    function automatic logic [L*DW-1:0] rnd_beat();
        logic [L*DW-1:0] b;
        for (int i = 0; i < L; i++) b[i*DW +: DW] = $urandom | $urandom;
        return b;
    endfunction

    task automatic run_vec(input logic [1:0] op, input logic [DW-1:0] seed, input int hold);
        logic [DW-1:0] exp;
        int n;
        exp = seed;
        n = beat_q.size();
        chk("idle_ready", 32'(in_ready), 0);
        chk("idle_busy", 32'(out_busy), 0);
        in_start = 1'b1; in_opSel = op; in_seed = seed;
        in_valid = 1'b1; in_last = 1'b1; in_data = rnd_beat(); in_mask = '1;
        @(negedge clk);
        in_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("accum_ready", 32'(in_ready), 1);
        chk("accum_busy", 32'(out_busy), 1);
        chk("accum_novalid", 32'(out_valid), 0);
        for (int b = 0; b < n; b++) begin
            repeat (gap_q[b]) begin
                in_start = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("stall_ready", 32'(in_ready), 1);
                chk("stall_novalid", 32'(out_valid), 0);
            end
            in_start = 1'($urandom_range(0, 1));
            in_valid = 1'b1; in_data = beat_q[b]; in_mask = mask_q[b]; in_last = (b == n - 1);
            exp = ref_fold(op, exp, beat_q[b], eff_mask(mask_q[b]));
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0; in_start = 1'b0;
            if (b < n - 1) chk("mid_novalid", 32'(out_valid), 0);
        end
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", 32'(out_valid), 1);
            chk("resp_data", out_data, exp);
            chk("resp_ready", 32'(in_ready), 0);
            last_res = out_data;
            out_ready = (h == hold);
            in_start = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        out_ready = 1'b0; in_start = 1'b0; in_valid = 1'b0;
        chk("post_valid", 32'(out_valid), 0);
        chk("post_busy", 32'(out_busy), 0);
        chk("post_ready", 32'(in_ready), 0);
        beat_q.delete(); mask_q.delete(); gap_q.delete();
    endtask

    task automatic push(input logic [L*DW-1:0] b, input logic [L-1:0] m, input int g);
        beat_q.push_back(b); mask_q.push_back(m); gap_q.push_back(g);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", 32'(out_busy), 0);
        rst = 1'b0;
        @(negedge clk);

        push({32'hFFFF0FFF, 32'hFFFFFFFF, 32'hF0F0FFFF, 32'hFF00FFFF}, '1, 0);
        run_vec(2'b01, 32'hFFFFFFFF, 0);
        chk("t1_and", last_res, 32'hF0000FFF);

        push({4{32'h00000003}}, '1, 0);
        push({4{32'h00000003}}, '1, 2);
        push({4{32'h00000003}}, '1, 0);
        run_vec(2'b11, 32'h1, 0);
        chk("t2_xor", last_res, 32'h00000001);

        push({32'h8, 32'h4, 32'h2, 32'h1}, '1, 0);
        run_vec(2'b10, 32'h0, 5);
        chk("t3_or", last_res, 32'h0000000F);

        in_start = 1'b1; in_opSel = 2'b10; in_seed = 32'h1234;
        @(negedge clk);
        in_start = 1'b0; in_valid = 1'b1; in_data = rnd_beat(); in_last = 1'b0;
        @(negedge clk);
        rst = 1'b1; in_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_ready", 32'(in_ready), 0);
        chk("t4_rst_valid", 32'(out_valid), 0);
        chk("t4_rst_busy", 32'(out_busy), 0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_idle_valid", 32'(out_valid), 0);
            chk("t4_idle_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        push(rnd_beat(), '1, 0);
        push(rnd_beat(), '1, 1);
        run_vec(2'b00, 32'h5, 1);
        chk("t4_pass", last_res, 32'h00000005);

`ifdef VRED_MASK_EN
        push({32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}, 4'b1010, 0);
        push({32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}, 4'b0000, 0);
        run_vec(2'b01, 32'hFFFFFFFF, 0);
        chk("t5_mask", last_res, 32'hFFFFFFFF);
`endif

        for (int t = 0; t < 40; t++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) push(rnd_beat(), 4'($urandom), $urandom_range(0, 2));
            run_vec(2'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
